imuldiv_div_arbiter: RTL and testbench

IMULDIV_DIV_ARBITER -- requirements
Module: imuldiv_DivArbiter

---
 rtl/imuldiv_div_arbiter_pkg.sv | 25 ++
 rtl/imuldiv_div_arbiter_rr_arb2.sv | 29 ++
 rtl/imuldiv_div_arbiter.sv | 139 +++++++++++++
 tb/tb_imuldiv_div_arbiter.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imuldiv_div_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// imuldiv_div_arbiter_pkg
// Shared definitions for the divider arbiter: FSM state encoding, requester
// port indices and divider request fn codes.
// No ports (package).
// -----------------------------------------------------------------------------
package imuldiv_div_arbiter_pkg;

   // Arbiter FSM states; encoding is fixed so waveforms and other blocks agree.
   typedef enum logic [1:0] {
      StIdle    = 2'b00,
      StIssue   = 2'b01,
      StWait    = 2'b10,
      StDeliver = 2'b11
   } div_arb_state_e;

   // Requester port indices.
   localparam logic Port0 = 1'b0;
   localparam logic Port1 = 1'b1;

   // DivReqMsg fn codes.
   localparam logic DivFnUnsigned = 1'b0;
   localparam logic DivFnSigned   = 1'b1;

endpackage

// File: rtl/imuldiv_div_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// imuldiv_div_arbiter_rr_arb2
// Two-way round-robin grant (imuldiv_RRArb2). Purely combinational.
// Ports:
//   req0_val_i    port 0 wants service
//   req1_val_i    port 1 wants service
//   last_grant_i  index of the port most recently served
//   grant_o       one-hot grant, bit N = port N
// -----------------------------------------------------------------------------
module imuldiv_div_arbiter_rr_arb2
   import imuldiv_div_arbiter_pkg::*;
(
   input  logic       req0_val_i,
   input  logic       req1_val_i,
   input  logic       last_grant_i,
   output logic [1:0] grant_o
);

   // On contention the port that was not served last wins.
   always_comb begin
      grant_o = 2'b00;
      if (req0_val_i && (!req1_val_i || (last_grant_i == Port1))) begin
         grant_o = 2'b01;
      end else if (req1_val_i) begin
         grant_o = 2'b10;
      end
   end

endmodule

// File: rtl/imuldiv_div_arbiter.sv
// -----------------------------------------------------------------------------
// imuldiv_div_arbiter
// Shares one iterative divider between two val/rdy requesters, one
// transaction in flight at a time.
// Ports:
//   clk, reset                    clock, asynchronous active-low reset
//   req{0,1}_val/rdy/fn/a/b       requester request channels
//   resp{0,1}_val/rdy/result      requester response channels {rem, quot}
//   div_req_val/rdy/fn/a/b        request channel toward the divider
//   div_resp_val/rdy/result       response channel from the divider
// -----------------------------------------------------------------------------
module imuldiv_div_arbiter
   import imuldiv_div_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_val,
   output logic        req0_rdy,
   input  logic        req0_fn,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   output logic        resp0_val,
   input  logic        resp0_rdy,
   output logic [63:0] resp0_result,
   input  logic        req1_val,
   output logic        req1_rdy,
   input  logic        req1_fn,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        resp1_val,
   input  logic        resp1_rdy,
   output logic [63:0] resp1_result,
   output logic        div_req_val,
   input  logic        div_req_rdy,
   output logic        div_req_fn,
   output logic [31:0] div_req_a,
   output logic [31:0] div_req_b,
   input  logic        div_resp_val,
   output logic        div_resp_rdy,
   input  logic [63:0] div_resp_result
);

   div_arb_state_e state_q;
   logic           last_grant_q;
   logic           owner_q;
   logic           fn_q;
   logic [31:0]    a_q;
   logic [31:0]    b_q;
   logic [63:0]    result_q;
   logic           div_req_val_q;
   logic           div_resp_rdy_q;
   logic           resp0_val_q;
   logic           resp1_val_q;
   logic [1:0]     grant;

   imuldiv_div_arbiter_rr_arb2 u_rr_arb2 (
      .req0_val_i   (req0_val),
      .req1_val_i   (req1_val),
      .last_grant_i (last_grant_q),
      .grant_o      (grant)
   );

   // The only input-to-handshake combinational path. Gated by reset so the
   // ready lines stay low while reset is held even though state reads IDLE.
   assign req0_rdy = reset && (state_q == StIdle) && grant[0];
   assign req1_rdy = reset && (state_q == StIdle) && grant[1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= StIdle;
         last_grant_q   <= Port1;
         owner_q        <= Port0;
         fn_q           <= 1'b0;
         a_q            <= '0;
         b_q            <= '0;
         result_q       <= '0;
         div_req_val_q  <= 1'b0;
         div_resp_rdy_q <= 1'b0;
         resp0_val_q    <= 1'b0;
         resp1_val_q    <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (req0_val && req0_rdy) begin
                  fn_q          <= req0_fn;
                  a_q           <= req0_a;
                  b_q           <= req0_b;
                  owner_q       <= Port0;
                  div_req_val_q <= 1'b1;
                  state_q       <= StIssue;
               end else if (req1_val && req1_rdy) begin
                  fn_q          <= req1_fn;
                  a_q           <= req1_a;
                  b_q           <= req1_b;
                  owner_q       <= Port1;
                  div_req_val_q <= 1'b1;
                  state_q       <= StIssue;
               end
            end
            StIssue: begin
               if (div_req_rdy) begin
                  div_req_val_q  <= 1'b0;
                  div_resp_rdy_q <= 1'b1;
                  state_q        <= StWait;
               end
            end
            StWait: begin
               if (div_resp_val) begin
                  result_q       <= div_resp_result;
                  div_resp_rdy_q <= 1'b0;
                  resp0_val_q    <= (owner_q == Port0);
                  resp1_val_q    <= (owner_q == Port1);
                  state_q        <= StDeliver;
               end
            end
            StDeliver: begin
               if ((owner_q == Port0) ? resp0_rdy : resp1_rdy) begin
                  last_grant_q <= owner_q;
                  resp0_val_q  <= 1'b0;
                  resp1_val_q  <= 1'b0;
                  state_q      <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign div_req_val  = div_req_val_q;
   assign div_req_fn   = fn_q;
   assign div_req_a    = a_q;
   assign div_req_b    = b_q;
   assign div_resp_rdy = div_resp_rdy_q;
   assign resp0_val    = resp0_val_q;
   assign resp1_val    = resp1_val_q;
   assign resp0_result = result_q;
   assign resp1_result = result_q;

endmodule

// File: tb/tb_imuldiv_div_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imuldiv_div_arbiter
// Self-checking bench for imuldiv_div_arbiter with a behavioural divider and
// a round-robin / arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_imuldiv_div_arbiter;
   import imuldiv_div_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_val, req0_rdy, req0_fn;
   logic [31:0] req0_a, req0_b;
   logic        resp0_val, resp0_rdy;
   logic [63:0] resp0_result;
   logic        req1_val, req1_rdy, req1_fn;
   logic [31:0] req1_a, req1_b;
   logic        resp1_val, resp1_rdy;
   logic [63:0] resp1_result;
   logic        div_req_val, div_req_rdy, div_req_fn;
   logic [31:0] div_req_a, div_req_b;
   logic        div_resp_val, div_resp_rdy;
   logic [63:0] div_resp_result;

   int tests = 0;
   int fails = 0;
   int last_served = 1;

   imuldiv_div_arbiter dut (
      .clk             (clk),
      .reset           (reset),
      .req0_val        (req0_val),
      .req0_rdy        (req0_rdy),
      .req0_fn         (req0_fn),
      .req0_a          (req0_a),
      .req0_b          (req0_b),
      .resp0_val       (resp0_val),
      .resp0_rdy       (resp0_rdy),
      .resp0_result    (resp0_result),
      .req1_val        (req1_val),
      .req1_rdy        (req1_rdy),
      .req1_fn         (req1_fn),
      .req1_a          (req1_a),
      .req1_b          (req1_b),
      .resp1_val       (resp1_val),
      .resp1_rdy       (resp1_rdy),
      .resp1_result    (resp1_result),
      .div_req_val     (div_req_val),
      .div_req_rdy     (div_req_rdy),
      .div_req_fn      (div_req_fn),
      .div_req_a       (div_req_a),
      .div_req_b       (div_req_b),
      .div_resp_val    (div_resp_val),
      .div_resp_rdy    (div_resp_rdy),
      .div_resp_result (div_resp_result)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   // {remainder, quotient}, truncating division.
   function automatic logic [63:0] ref_div(input logic fn, input logic [31:0] a,
                                           input logic [31:0] b);
      int sa, sb;
      logic [31:0] q, r;
      if (fn) begin
         sa = a;
         sb = b;
         q  = sa / sb;
         r  = sa % sb;
      end else begin
         q = a / b;
         r = a % b;
      end
      return {r, q};
   endfunction

   // Round-robin: single requester wins; on contention the one not served last.
   function automatic int exp_winner(input bit v0, input bit v1);
      if (v0 && v1) return (last_served == 0) ? 1 : 0;
      return v0 ? 0 : 1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      req0_val = 0; req1_val = 0; resp0_rdy = 0; resp1_rdy = 0;
      div_req_rdy = 0; div_resp_val = 0;
      step();
      step();
      reset = 1'b1;
      step();
      last_served = 1;
   endtask

   // Behavioural divider plus response consumer for one accepted request.
   task automatic serve(input int req_stall, input int resp_lat, input int del_stall,
                        output logic [63:0] res, output int port, output bit stable,
                        output bit wait_ok, output bit timeout);
      logic        f;
      logic [31:0] oa, ob;
      logic [63:0] dres;
      int n;
      stable = 1; wait_ok = 1; timeout = 0; port = -1; res = '0;
      #1;
      n = 0;
      while (div_req_val !== 1'b1 && n < 8) begin
         step(); #1; n++;
      end
      if (div_req_val !== 1'b1) begin
         timeout = 1;
         return;
      end
      f = div_req_fn; oa = div_req_a; ob = div_req_b;
      // Spurious divider response outside WAIT must be ignored.
      div_resp_val = 1'b1;
      div_resp_result = {$urandom, $urandom};
      for (int i = 0; i < req_stall; i++) begin
         step(); #1;
         if (div_req_val !== 1'b1 || div_req_fn !== f || div_req_a !== oa ||
             div_req_b !== ob || req0_rdy !== 1'b0 || req1_rdy !== 1'b0 ||
             div_resp_rdy !== 1'b0) stable = 0;
      end
      div_req_rdy = 1'b1;
      step();
      div_req_rdy = 1'b0;
      div_resp_val = 1'b0;
      #1;
      if (div_resp_rdy !== 1'b1 || div_req_val !== 1'b0) wait_ok = 0;
      dres = ref_div(f, oa, ob);
      for (int i = 0; i < resp_lat; i++) begin
         step(); #1;
         if (div_resp_rdy !== 1'b1 || resp0_val !== 1'b0 || resp1_val !== 1'b0) stable = 0;
      end
      div_resp_val = 1'b1;
      div_resp_result = dres;
      step();
      div_resp_val = 1'b0;
      div_resp_result = {$urandom, $urandom};
      #1;
      if (resp0_val === 1'b1 && resp1_val === 1'b0) port = 0;
      else if (resp1_val === 1'b1 && resp0_val === 1'b0) port = 1;
      else begin
         timeout = 1;
         return;
      end
      res = (port == 1) ? resp1_result : resp0_result;
      for (int i = 0; i < del_stall; i++) begin
         step(); #1;
         if (((port == 1) ? resp1_val : resp0_val) !== 1'b1 ||
             ((port == 1) ? resp1_result : resp0_result) !== res ||
             ((port == 1) ? resp0_val : resp1_val) !== 1'b0 ||
             req0_rdy !== 1'b0 || req1_rdy !== 1'b0 || div_resp_rdy !== 1'b0) stable = 0;
      end
      if (port == 1) resp1_rdy = 1'b1;
      else           resp0_rdy = 1'b1;
      step();
      resp0_rdy = 1'b0;
      resp1_rdy = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      req0_val = 1; req1_val = 1; div_resp_val = 1; resp0_rdy = 1; resp1_rdy = 1;
      div_req_rdy = 1;
      #1;
      tests++;
      if ({req0_rdy, req1_rdy, resp0_val, resp1_val, div_req_val, div_resp_rdy} !== 6'b0)
         begin
         fails++;
         $display("FAIL reset_handshake: got %b expected 000000",
                  {req0_rdy, req1_rdy, resp0_val, resp1_val, div_req_val, div_resp_rdy});
      end
      tests++;
      if ({resp0_result, div_req_a, div_req_b, div_req_fn} !== 129'b0) begin
         fails++;
         $display("FAIL reset_regs: got %h expected 0",
                  {resp0_result, div_req_a, div_req_b, div_req_fn});
      end
      step();
      req0_val = 0; req1_val = 0; div_resp_val = 0; resp0_rdy = 0; resp1_rdy = 0;
      div_req_rdy = 0;
      reset = 1'b1;
      step();
      last_served = 1;
   endtask

   task automatic test_signed_p0();
      logic [63:0] res; int port; bit st, wo, to;
      req0_fn = DivFnSigned; req0_a = 32'hFFFF_FFF9; req0_b = 32'd2;
      req0_val = 1; req1_val = 0;
      #1;
      tests++;
      if ({req1_rdy, req0_rdy} !== 2'b01) begin
         fails++;
         $display("FAIL signed_grant: got %b expected 01", {req1_rdy, req0_rdy});
      end
      step();
      req0_val = 0;
      #1;
      tests++;
      if ({div_req_val, div_req_fn, div_req_a, div_req_b} !== {1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2})
         begin
         fails++;
         $display("FAIL signed_issue: got %h expected %h",
                  {div_req_val, div_req_fn, div_req_a, div_req_b},
                  {1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2});
      end
      serve(0, 2, 0, res, port, st, wo, to);
      tests++;
      if (to || port != 0) begin
         fails++;
         $display("FAIL signed_port: got port %0d timeout %0d expected port 0", port, to);
      end
      tests++;
      if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin
         fails++;
         $display("FAIL signed_result: got %h expected ffffffff_fffffffd", res);
      end
      last_served = 0;
   endtask

   task automatic test_simultaneous();
      logic [63:0] res; int port; bit st, wo, to; int w;
      do_reset();
      req0_fn = DivFnUnsigned; req0_a = 32'd100; req0_b = 32'd7;
      req1_fn = DivFnUnsigned; req1_a = 32'd50;  req1_b = 32'd3;
      req0_val = 1; req1_val = 1;
      #1;
      w = exp_winner(1, 1);
      tests++;
      if ({req1_rdy, req0_rdy} !== ((w == 1) ? 2'b10 : 2'b01)) begin
         fails++;
         $display("FAIL sim_grant_a: got %b expected port %0d", {req1_rdy, req0_rdy}, w);
      end
      step();
      // Port 0 immediately re-requests while port 1 is still waiting.
      req0_a = 32'd81; req0_b = 32'd4;
      serve(0, 1, 0, res, port, st, wo, to);
      tests++;
      if (to || port != 0 || res !== {32'd2, 32'd14}) begin
         fails++;
         $display("FAIL sim_first: got port %0d result %h expected port 0 result %h",
                  port, res, {32'd2, 32'd14});
      end
      last_served = 0;
      #1;
      w = exp_winner(1, 1);
      tests++;
      if ({req1_rdy, req0_rdy} !== ((w == 1) ? 2'b10 : 2'b01)) begin
         fails++;
         $display("FAIL sim_grant_b: got %b expected port %0d", {req1_rdy, req0_rdy}, w);
      end
      step();
      req1_val = 0;
      serve(1, 0, 1, res, port, st, wo, to);
      tests++;
      if (to || port != 1 || res !== {32'd2, 32'd16}) begin
         fails++;
         $display("FAIL sim_second: got port %0d result %h expected port 1 result %h",
                  port, res, {32'd2, 32'd16});
      end
      last_served = 1;
      step();
      req0_val = 0;
      serve(0, 0, 0, res, port, st, wo, to);
      tests++;
      if (to || port != 0 || res !== {32'd1, 32'd20}) begin
         fails++;
         $display("FAIL sim_third: got port %0d result %h expected port 0 result %h",
                  port, res, {32'd1, 32'd20});
      end
      last_served = 0;
      // Second simultaneous pair: port 1 was not served last, so it goes first.
      req0_a = 32'd9;    req0_b = 32'd2;
      req1_a = 32'd1000; req1_b = 32'd10;
      req0_val = 1; req1_val = 1;
      #1;
      w = exp_winner(1, 1);
      tests++;
      if (w != 1 || {req1_rdy, req0_rdy} !== 2'b10) begin
         fails++;
         $display("FAIL sim_pair2_grant: got %b expected 10", {req1_rdy, req0_rdy});
      end
      step();
      req1_val = 0;
      serve(0, 0, 0, res, port, st, wo, to);
      tests++;
      if (to || port != 1 || res !== {32'd0, 32'd100}) begin
         fails++;
         $display("FAIL sim_pair2_first: got port %0d result %h expected port 1 result %h",
                  port, res, {32'd0, 32'd100});
      end
      last_served = 1;
      step();
      req0_val = 0;
      serve(0, 0, 0, res, port, st, wo, to);
      tests++;
      if (to || port != 0 || res !== {32'd1, 32'd4}) begin
         fails++;
         $display("FAIL sim_pair2_second: got port %0d result %h expected port 0 result %h",
                  port, res, {32'd1, 32'd4});
      end
      last_served = 0;
   endtask

   task automatic test_deliver_backpressure();
      logic [63:0] res; int port; bit st, wo, to;
      req0_fn = DivFnUnsigned; req0_a = 32'hDEAD_BEEF; req0_b = 32'h1234;
      req0_val = 1; req1_val = 0;
      #1;
      step();
      // Both requesters hold val while busy; neither may see rdy.
      req1_val = 1;
      serve(0, 1, 5, res, port, st, wo, to);
      tests++;
      if (to || port != 0 || res !== ref_div(DivFnUnsigned, 32'hDEAD_BEEF, 32'h1234)) begin
         fails++;
         $display("FAIL deliver_bp_result: got port %0d result %h expected port 0 result %h",
                  port, res, ref_div(DivFnUnsigned, 32'hDEAD_BEEF, 32'h1234));
      end
      tests++;
      if (!st) begin
         fails++;
         $display("FAIL deliver_bp_stable: got unstable expected stable");
      end
      last_served = 0;
      // Both drop val before any grant edge: nothing may start.
      req0_val = 0; req1_val = 0;
      step();
      step();
      tests++;
      if ({div_req_val, resp0_val, resp1_val} !== 3'b000) begin
         fails++;
         $display("FAIL dropped_request: got %b expected 000", {div_req_val, resp0_val, resp1_val});
      end
   endtask

   task automatic test_issue_backpressure();
      logic [63:0] res; int port; bit st, wo, to;
      req1_fn = DivFnSigned; req1_a = -32'sd1000; req1_b = 32'd3;
      req1_val = 1; req0_val = 0;
      #1;
      tests++;
      if ({req1_rdy, req0_rdy} !== 2'b10) begin
         fails++;
         $display("FAIL issue_bp_grant: got %b expected 10", {req1_rdy, req0_rdy});
      end
      step();
      req1_val = 0;
      serve(3, 0, 0, res, port, st, wo, to);
      tests++;
      if (!st || !wo) begin
         fails++;
         $display("FAIL issue_bp_stable: got stable %0d wait %0d expected 1 1", st, wo);
      end
      tests++;
      if (to || port != 1 || res !== ref_div(DivFnSigned, -32'sd1000, 32'd3)) begin
         fails++;
         $display("FAIL issue_bp_result: got port %0d result %h expected port 1 result %h",
                  port, res, ref_div(DivFnSigned, -32'sd1000, 32'd3));
      end
      last_served = 1;
   endtask

   task automatic test_reset_mid();
      logic [63:0] res; int port; bit st, wo, to;
      req0_fn = DivFnUnsigned; req0_a = 32'd77; req0_b = 32'd5;
      req0_val = 1; req1_val = 0;
      #1;
      step();
      req0_val = 0;
      #1;
      div_req_rdy = 1;
      step();
      div_req_rdy = 0;
      #1;
      tests++;
      if (div_resp_rdy !== 1'b1) begin
         fails++;
         $display("FAIL mid_wait: got div_resp_rdy %b expected 1", div_resp_rdy);
      end
      req0_val = 1; req1_val = 1;
      #2;
      reset = 1'b0;
      #1;
      tests++;
      if ({req0_rdy, req1_rdy, resp0_val, resp1_val, div_req_val, div_resp_rdy} !== 6'b0)
         begin
         fails++;
         $display("FAIL mid_reset_outputs: got %b expected 000000",
                  {req0_rdy, req1_rdy, resp0_val, resp1_val, div_req_val, div_resp_rdy});
      end
      step();
      reset = 1'b1;
      last_served = 1;
      #1;
      tests++;
      if ({req1_rdy, req0_rdy} !== ((exp_winner(1, 1) == 0) ? 2'b01 : 2'b10)) begin
         fails++;
         $display("FAIL mid_reset_grant: got %b expected 01", {req1_rdy, req0_rdy});
      end
      req0_a = 32'd77; req0_b = 32'd5;
      step();
      req0_val = 0; req1_val = 0;
      serve(0, 0, 0, res, port, st, wo, to);
      tests++;
      if (to || port != 0 || res !== {32'd2, 32'd15}) begin
         fails++;
         $display("FAIL mid_reset_txn: got port %0d result %h expected port 0 result %h",
                  port, res, {32'd2, 32'd15});
      end
      last_served = 0;
   endtask

   task automatic test_random();
      logic [63:0] res, expv; int port; bit st, wo, to;
      int v, w;
      for (int k = 0; k < 30; k++) begin
         v = $urandom_range(1, 3);
         req0_fn = 1'($urandom_range(0, 1)); req0_a = $urandom;
         req0_b = $urandom_range(2, 1000);
         if ($urandom_range(0, 1) == 1) req0_b = -req0_b;
         req1_fn = 1'($urandom_range(0, 1)); req1_a = $urandom;
         req1_b = $urandom_range(2, 1000);
         if ($urandom_range(0, 1) == 1) req1_b = -req1_b;
         req0_val = v[0]; req1_val = v[1];
         #1;
         w = exp_winner(v[0], v[1]);
         expv = (w == 1) ? ref_div(req1_fn, req1_a, req1_b) : ref_div(req0_fn, req0_a, req0_b);
         tests++;
         if ({req1_rdy, req0_rdy} !== ((w == 1) ? 2'b10 : 2'b01)) begin
            fails++;
            $display("FAIL rand_grant[%0d]: got %b expected port %0d", k, {req1_rdy, req0_rdy}, w);
         end
         step();
         req0_val = 0; req1_val = 0;
         serve($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
               res, port, st, wo, to);
         tests++;
         if (to || port != w || res !== expv) begin
            fails++;
            $display("FAIL rand_result[%0d]: got port %0d result %h expected port %0d result %h",
                     k, port, res, w, expv);
         end
         tests++;
         if (!st || !wo) begin
            fails++;
            $display("FAIL rand_stable[%0d]: got stable %0d wait %0d expected 1 1", k, st, wo);
         end
         last_served = w;
      end
   endtask

   initial begin
      reset = 1'b0;
      req0_val = 0; req0_fn = 0; req0_a = '0; req0_b = '0; resp0_rdy = 0;
      req1_val = 0; req1_fn = 0; req1_a = '0; req1_b = '0; resp1_rdy = 0;
      div_req_rdy = 0; div_resp_val = 0; div_resp_result = '0;
      step();
      test_reset();
      test_signed_p0();
      test_simultaneous();
      test_deliver_backpressure();
      test_issue_backpressure();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
